reg_bank: RTL and testbench



---
 rtl/reg_bank_if.sv | 26 ++
 rtl/reg_bank.sv | 78 +++++++
 tb/tb_reg_bank.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_if.sv
// Bus between the writeback/operand-fetch stages and reg_bank.
// The master drives write and read-select inputs; the slave (reg_bank) returns read data and debug outputs.
interface reg_bank_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 6
);
  logic [DATA_W-1:0] DATA_IN;
  logic [SEL_W-1:0]  SEL_IN;
  logic              UPDATE_FLAG;
  logic [SEL_W-1:0]  SEL_A;
  logic [SEL_W-1:0]  SEL_B;
  logic [DATA_W-1:0] RD_A;
  logic [DATA_W-1:0] RD_B;
  logic [DATA_W-1:0] W_OUT;
  logic [15:0]       WR_COUNT;

  modport master (
    output DATA_IN, SEL_IN, UPDATE_FLAG, SEL_A, SEL_B,
    input  RD_A, RD_B, W_OUT, WR_COUNT
  );

  modport slave (
    input  DATA_IN, SEL_IN, UPDATE_FLAG, SEL_A, SEL_B,
    output RD_A, RD_B, W_OUT, WR_COUNT
  );
endinterface

// File: rtl/reg_bank.sv
// 64 x 16 register file with toggle-encoded write strobe, two registered read ports, W output and write counter.
// Optional macro REG_BANK_BYPASS_EN: forward same-cycle write data onto colliding read ports.
module reg_bank #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned SEL_W     = 6,
  parameter int unsigned W_ADDR    = 34,
  parameter int unsigned NULL_ADDR = 63
) (
  input logic       clk,
  input logic       rst,
  reg_bank_if.slave bus
);

  localparam int unsigned NUM_REGS = 1 << SEL_W;
  localparam int unsigned CNT_W    = 16;

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              r_prev_flag;
  logic [DATA_W-1:0] r_rd_a;
  logic [DATA_W-1:0] r_rd_b;
  logic [CNT_W-1:0]  r_wr_count;

  logic w_wr_pulse;
  logic w_wr_en;
  logic w_fwd_a;
  logic w_fwd_b;

  // Each level change of UPDATE_FLAG is one write; the null address swallows it.
  assign w_wr_pulse = bus.UPDATE_FLAG ^ r_prev_flag;
  assign w_wr_en    = w_wr_pulse && (bus.SEL_IN != SEL_W'(NULL_ADDR));

`ifdef REG_BANK_BYPASS_EN
  assign w_fwd_a = w_wr_en && (bus.SEL_IN == bus.SEL_A);
  assign w_fwd_b = w_wr_en && (bus.SEL_IN == bus.SEL_B);
`else
  assign w_fwd_a = 1'b0;
  assign w_fwd_b = 1'b0;
`endif

  // Tracks the flag level even during reset so the first write needs a fresh toggle.
  always_ff @(posedge clk) begin
    r_prev_flag <= bus.UPDATE_FLAG;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[bus.SEL_IN] <= bus.DATA_IN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_count <= '0;
    end else if (w_wr_en) begin
      r_wr_count <= r_wr_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
    end else begin
      r_rd_a <= w_fwd_a ? bus.DATA_IN : r_mem[bus.SEL_A];
      r_rd_b <= w_fwd_b ? bus.DATA_IN : r_mem[bus.SEL_B];
    end
  end

  assign bus.RD_A     = r_rd_a;
  assign bus.RD_B     = r_rd_b;
  assign bus.W_OUT    = r_mem[SEL_W'(W_ADDR)];
  assign bus.WR_COUNT = r_wr_count;

endmodule

// File: tb/tb_reg_bank.sv
// Randomised self-checking bench for reg_bank against a behavioural register-file model.
// Build with or without REG_BANK_BYPASS_EN; the model follows the same macro.
module tb_reg_bank;

  logic clk;
  logic rst;

  reg_bank_if #(.DATA_W(16), .SEL_W(6)) bus ();

  reg_bank dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: an array of 64 words, a counter and the last flag level.
  logic [15:0] m_mem [64];
  logic [15:0] m_cnt;
  logic [15:0] m_rd_a;
  logic [15:0] m_rd_b;
  logic        m_prev;
  logic        m_valid = 1'b0;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always @(posedge clk) begin
    logic pulse;
    logic do_wr;
    if (rst) begin
      for (int i = 0; i < 64; i++) m_mem[i] = 16'h0;
      m_cnt   = 16'h0;
      m_rd_a  = 16'h0;
      m_rd_b  = 16'h0;
      m_valid = 1'b1;
    end else begin
      pulse = (bus.UPDATE_FLAG != m_prev);
      do_wr = pulse && (bus.SEL_IN != 6'd63);
      m_rd_a = (BYPASS && do_wr && bus.SEL_IN == bus.SEL_A) ? bus.DATA_IN : m_mem[bus.SEL_A];
      m_rd_b = (BYPASS && do_wr && bus.SEL_IN == bus.SEL_B) ? bus.DATA_IN : m_mem[bus.SEL_B];
      if (do_wr) begin
        m_mem[bus.SEL_IN] = bus.DATA_IN;
        m_cnt = m_cnt + 16'd1;
      end
    end
    m_prev = bus.UPDATE_FLAG;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("rd_a_model", bus.RD_A, m_rd_a);
      check("rd_b_model", bus.RD_B, m_rd_b);
      check("w_out_model", bus.W_OUT, m_mem[34]);
      check("wr_count_model", bus.WR_COUNT, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] sel_in, input logic [15:0] data, input logic flag);
    bus.SEL_IN      = sel_in;
    bus.DATA_IN     = data;
    bus.UPDATE_FLAG = flag;
  endtask

  initial begin
    rst             = 1'b1;
    bus.DATA_IN     = 16'h0;
    bus.SEL_IN      = 6'd0;
    bus.UPDATE_FLAG = 1'b1;
    bus.SEL_A       = 6'd0;
    bus.SEL_B       = 6'd0;
    step();
    step();
    check("reset_wr_count", bus.WR_COUNT, 16'h0);
    check("reset_rd_a", bus.RD_A, 16'h0);

    // Constant flag level after release: no writes.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.SEL_A = 6'(i * 13);
      bus.SEL_B = 6'(63 - i * 7);
      step();
      check("idle_rd_a", bus.RD_A, 16'h0);
      check("idle_rd_b", bus.RD_B, 16'h0);
    end
    check("idle_wr_count", bus.WR_COUNT, 16'h0);

    drive(6'd5, 16'h1234, 1'b0);
    step();
    bus.SEL_A = 6'd5;
    step();
    check("wr5_rd_a", bus.RD_A, 16'h1234);
    check("wr5_count", bus.WR_COUNT, 16'd1);

    drive(6'd34, 16'hBEEF, 1'b1);
    step();
    check("w_out_beef", bus.W_OUT, 16'hBEEF);
    bus.SEL_B = 6'd34;
    step();
    check("rd_b_beef", bus.RD_B, 16'hBEEF);

    drive(6'd63, 16'hFFFF, 1'b0);
    step();
    bus.SEL_A = 6'd63;
    step();
    check("null_rd_a", bus.RD_A, 16'h0);
    check("null_count", bus.WR_COUNT, 16'd2);

    drive(6'd7, 16'h5555, 1'b1);
    step();
    bus.SEL_A = 6'd7;
    drive(6'd7, 16'hAAAA, 1'b0);
    step();
    check("collide_rd_a", bus.RD_A, BYPASS ? 16'hAAAA : 16'h5555);
    step();
    check("collide_rd_a_next", bus.RD_A, 16'hAAAA);
    check("collide_count", bus.WR_COUNT, 16'd4);

    // Randomised traffic with biased collisions, null/W hits and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] s;
      case ($urandom_range(0, 5))
        0:       s = 6'd63;
        1:       s = 6'd34;
        default: s = 6'($urandom_range(0, 63));
      endcase
      drive(s, 16'($urandom), ($urandom_range(0, 1) == 1) ? ~bus.UPDATE_FLAG : bus.UPDATE_FLAG);
      bus.SEL_A = ($urandom_range(0, 3) == 0) ? s : 6'($urandom_range(0, 63));
      bus.SEL_B = ($urandom_range(0, 3) == 0) ? s : 6'($urandom_range(0, 63));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    // Counter wrap: 65536 back-to-back writes to address 1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.SEL_A = 6'd1;
    bus.SEL_B = 6'd34;
    for (int i = 0; i < 65536; i++) begin
      drive(6'd1, 16'(i), ~bus.UPDATE_FLAG);
      step();
      if (i == 65534) check("wrap_pre", bus.WR_COUNT, 16'hFFFF);
    end
    check("wrap_zero", bus.WR_COUNT, 16'h0);
    step();
    check("wrap_last_data", bus.RD_A, 16'hFFFF);

    // Toggle coinciding with reset is discarded.
    rst = 1'b1;
    drive(6'd1, 16'h4321, ~bus.UPDATE_FLAG);
    step();
    check("rst_toggle_count", bus.WR_COUNT, 16'h0);
    check("rst_toggle_rd_a", bus.RD_A, 16'h0);
    check("rst_toggle_w_out", bus.W_OUT, 16'h0);
    rst = 1'b0;
    step();
    check("post_rst_rd_a", bus.RD_A, 16'h0);
    check("post_rst_count", bus.WR_COUNT, 16'h0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
